gobou_writeback: RTL and testbench
==================================

# gobou_writeback

Downstream write-back stage of the gobou fully-connected engine. Accepts one CORE-wide vector of output neurons per handshake from the core array, serializes it element-by-element, and writes each element into the image memory at consecutive addresses from a programmed base. Handles a final partial group when the layer's output count is not a multiple of CORE, then signals completion to the controller.

## Interface
- DWIDTH, 16, data word width (signed)
- IMGSIZE, 12, image memory address width
- LWIDTH, 10, layer-size counter width
- CORE, 8, parallel lanes per input vector
- CORELOG, 3, log2(CORE)

- clk  in  1  clock
- xrst  in  1  reset; one clock, reset asynchronous and active-high
- start  in  1  one-cycle pulse: begin a layer
- base_addr  in  IMGSIZE  first output address, sampled on start
- total_out  in  LWIDTH  output neurons in layer, sampled on start
- in_valid  in  1  in_data holds a valid vector
- in_data  in  CORE×DWIDTH  signed lane results, lane 0 first in address order
- in_ready  out  1  block can accept a vector this cycle
- mem_img_we  out  1  image memory write enable
- mem_img_addr  out  IMGSIZE  write address
- write_mem_img  out  DWIDTH  signed write data
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse: all total_out elements written

## Operation
- States: IDLE, WAIT, DRAIN, FIN.
- IDLE: in_ready=0. start latches base_addr, total_out; clears written-count; -> FIN if total_out==0, else WAIT. in_valid ignored.
- WAIT: in_ready=1. On in_valid&&in_ready, capture all CORE lanes into buffer, set group length n = min(CORE, total_out − written); -> DRAIN.
- DRAIN: one write per cycle, lane k=0..n−1, addr = base_addr + written (mod 2^IMGSIZE), written++ each write. On lane n−1: if written reaches total_out -> FIN; else in_ready=1 this cycle and a simultaneous in_valid captures the next vector with no bubble (stay DRAIN, k=0); otherwise -> WAIT.
- Lanes n..CORE−1 of a partial last group are discarded, never written.
- FIN: done=1 for one cycle, -> IDLE.
- busy=1 in WAIT, DRAIN, FIN.
- start outside IDLE ignored; base_addr/total_out changes after start have no effect.
- Address arithmetic modulo 2^IMGSIZE (wraps silently).
- Reset (any state, any time): state IDLE; all outputs 0 (in_ready, mem_img_we, mem_img_addr, write_mem_img, busy, done); counters and buffer cleared. Partially written layer abandoned.

## Timing
- All outputs registered.
- Vector accepted at edge E: write of lane k visible in cycle following edge E+k; n writes in n consecutive cycles.
- done high in cycle immediately after last write cycle.
- total_out==0: done high in cycle following the edge after start's edge; no writes.
- Back-to-back: sustained throughput of 1 write/cycle when in_valid is held high.
- Minimum latency start -> first write: 2 cycles when in_valid is already high at WAIT.

## Configuration
- WB_RELU_EN defined: each lane clamped at capture, negative values become 0, non-negative unchanged.
- WB_RELU_EN undefined: lanes written unmodified (signed passthrough).

## Structure
- FSM state enum typedef and default width constants live in shared gobou.svh alongside DWIDTH/CORE/IMGSIZE.
- One sub-module: gobou_relu (per-lane combinational clamp, instantiated CORE times only under WB_RELU_EN).
- Buffer, lane counter, written counter, address register in top of block.

## Test plan
- total_out=8, base_addr=0x100, one vector 1..8, in_valid held -> writes addr 0x100..0x107 data 1..8 on 8 consecutive cycles; done 1 cycle later.
- total_out=11, two vectors (10..17, 20..27) -> 11 writes 0x000..0x00A, data 10..17,20,21,22; lanes 3..7 of second vector never written.
- total_out=16, in_valid held continuously -> 16 writes with no idle cycle; in_ready high on cycle of 8th write.
- total_out=0, start -> done pulse, mem_img_we never asserted, busy for 1 cycle.
- base_addr=0xFFE, total_out=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Vector with −5 in lane 0, xrst asserted mid-DRAIN -> with WB_RELU_EN lane 0 writes 0, without writes −5; after xrst all outputs 0, state IDLE, start needed to resume.

Source files
------------

// File: rtl/gobou_writeback_pkg.sv
// Shared widths and FSM encoding for the gobou write-back stage.
package gobou_writeback_pkg;
    localparam int WB_DWIDTH  = 16;
    localparam int WB_IMGSIZE = 12;
    localparam int WB_LWIDTH  = 10;
    localparam int WB_CORE    = 8;
    localparam int WB_CORELOG = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } wb_state_e;
endpackage

// File: rtl/gobou_writeback_if.sv
// Vector hand-off from the core array into the write-back stage.
interface gobou_writeback_if
    import gobou_writeback_pkg::*;
#(
    parameter int DWIDTH = WB_DWIDTH,
    parameter int CORE   = WB_CORE
);
    logic                     in_valid;
    logic [CORE*DWIDTH-1:0]   in_data;
    logic                     in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/gobou_writeback_relu.sv
// Per-lane clamp used at vector capture: negative words become zero.
module gobou_writeback_relu
    import gobou_writeback_pkg::*;
#(
    parameter int DWIDTH = WB_DWIDTH
) (
    input  logic signed [DWIDTH-1:0] din,
    output logic signed [DWIDTH-1:0] dout
);
    assign dout = din[DWIDTH-1] ? '0 : din;
endmodule

// File: rtl/gobou_writeback.sv
// Write-back stage: serializes CORE-wide neuron vectors into image memory.
// Define WB_RELU_EN to clamp negative lanes to zero at capture.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_WAIT  | in_ready high, waiting for the next vector
// S_DRAIN | writing one buffered lane per cycle
// S_FIN   | done pulse, then back to idle
module gobou_writeback
    import gobou_writeback_pkg::*;
#(
    parameter int DWIDTH  = WB_DWIDTH,
    parameter int IMGSIZE = WB_IMGSIZE,
    parameter int LWIDTH  = WB_LWIDTH,
    parameter int CORE    = WB_CORE,
    parameter int CORELOG = WB_CORELOG
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      start,
    input  logic [IMGSIZE-1:0]        base_addr,
    input  logic [LWIDTH-1:0]         total_out,
    gobou_writeback_if.slave          vec,
    output logic                      mem_img_we,
    output logic [IMGSIZE-1:0]        mem_img_addr,
    output logic signed [DWIDTH-1:0]  write_mem_img,
    output logic                      busy,
    output logic                      done
);
    localparam int LEN_W = CORELOG + 1;

    typedef logic signed [DWIDTH-1:0] word_t;

    wb_state_e          state_q, state_n;
    logic [IMGSIZE-1:0] base_q, base_n;
    logic [LWIDTH-1:0]  total_q, total_n;
    logic [LWIDTH-1:0]  written_q, written_n;
    logic [CORELOG-1:0] lane_q, lane_n;
    logic [LEN_W-1:0]   len_q, len_n;
    word_t              buf_q [CORE];
    word_t              buf_n [CORE];
    word_t              lane_in [CORE];

    logic               ready_q, ready_n;
    logic               we_q, we_n;
    logic [IMGSIZE-1:0] addr_q, addr_n;
    word_t              data_q, data_n;
    logic               busy_q, done_q;

    logic [LWIDTH-1:0]  remaining;
    logic [LEN_W-1:0]   grp_len;
    logic               last_lane;
    logic [CORELOG-1:0] lane_inc;
    logic [IMGSIZE-1:0] wr_addr;
    logic               more_left;
    logic               accept;

    for (genvar g = 0; g < CORE; g++) begin : g_lane
`ifdef WB_RELU_EN
        gobou_writeback_relu #(.DWIDTH(DWIDTH)) u_relu (
            .din  (vec.in_data[g*DWIDTH +: DWIDTH]),
            .dout (lane_in[g])
        );
`else
        assign lane_in[g] = vec.in_data[g*DWIDTH +: DWIDTH];
`endif
    end

    always_comb begin
        remaining = total_q - written_q;
        grp_len   = (remaining >= LWIDTH'(CORE)) ? LEN_W'(CORE) : LEN_W'(remaining);
        last_lane = (({1'b0, lane_q} + LEN_W'(1)) == len_q);
        lane_inc  = lane_q + CORELOG'(1);
        wr_addr   = base_q + IMGSIZE'(written_q);
        // true when the write being issued now is not the layer's final element
        more_left = ((written_q + LWIDTH'(1)) != total_q);
    end

    always_comb begin
        state_n   = state_q;
        base_n    = base_q;
        total_n   = total_q;
        written_n = written_q;
        lane_n    = lane_q;
        len_n     = len_q;
        buf_n     = buf_q;
        we_n      = 1'b0;
        addr_n    = addr_q;
        data_n    = data_q;
        ready_n   = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_n    = base_addr;
                    total_n   = total_out;
                    written_n = '0;
                    state_n   = (total_out == '0) ? S_FIN : S_WAIT;
                    ready_n   = (total_out != '0);
                end
            end
            S_WAIT: begin
                if (vec.in_valid && ready_q) accept  = 1'b1;
                else                         ready_n = 1'b1;
            end
            S_DRAIN: begin
                if (!last_lane) begin
                    we_n      = 1'b1;
                    addr_n    = wr_addr;
                    data_n    = buf_q[lane_inc];
                    written_n = written_q + LWIDTH'(1);
                    lane_n    = lane_inc;
                    ready_n   = (({1'b0, lane_q} + LEN_W'(2)) == len_q) && more_left;
                end else if (written_q == total_q) begin
                    state_n = S_FIN;
                end else if (vec.in_valid && ready_q) begin
                    accept = 1'b1;
                end else begin
                    state_n = S_WAIT;
                    ready_n = 1'b1;
                end
            end
            S_FIN: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // lane 0 goes out on the capture edge; the rest drain from the buffer
        if (accept) begin
            buf_n     = lane_in;
            we_n      = 1'b1;
            addr_n    = wr_addr;
            data_n    = lane_in[0];
            written_n = written_q + LWIDTH'(1);
            lane_n    = '0;
            len_n     = grp_len;
            state_n   = S_DRAIN;
            ready_n   = (grp_len == LEN_W'(1)) && more_left;
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            total_q   <= '0;
            written_q <= '0;
            lane_q    <= '0;
            len_q     <= '0;
            buf_q     <= '{default: '0};
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            base_q    <= base_n;
            total_q   <= total_n;
            written_q <= written_n;
            lane_q    <= lane_n;
            len_q     <= len_n;
            buf_q     <= buf_n;
            ready_q   <= ready_n;
            we_q      <= we_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            busy_q    <= (state_n != S_IDLE);
            done_q    <= (state_n == S_FIN);
        end
    end

    assign vec.in_ready  = ready_q;
    assign mem_img_we    = we_q;
    assign mem_img_addr  = addr_q;
    assign write_mem_img = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_gobou_writeback.sv
// Self-checking bench for gobou_writeback: queue-based reference model plus directed literal cases.
`timescale 1ns/1ps
module tb_gobou_writeback;
    import gobou_writeback_pkg::*;

    localparam int DW = WB_DWIDTH;
    localparam int AW = WB_IMGSIZE;
    localparam int LW = WB_LWIDTH;
    localparam int NC = WB_CORE;

    logic                 clk = 1'b0;
    logic                 xrst = 1'b1;
    logic                 start = 1'b0;
    logic [AW-1:0]        base_addr = '0;
    logic [LW-1:0]        total_out = '0;
    logic                 mem_img_we;
    logic [AW-1:0]        mem_img_addr;
    logic signed [DW-1:0] write_mem_img;
    logic                 busy;
    logic                 done;

    gobou_writeback_if #(.DWIDTH(DW), .CORE(NC)) vec ();

    gobou_writeback dut (
        .clk           (clk),
        .xrst          (xrst),
        .start         (start),
        .base_addr     (base_addr),
        .total_out     (total_out),
        .vec           (vec),
        .mem_img_we    (mem_img_we),
        .mem_img_addr  (mem_img_addr),
        .write_mem_img (write_mem_img),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: pending writes as a queue of (addr, data)
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           pend[$];
    bit            m_active, m_done, m_ready, m_busy, m_acc_now;
    int            m_total, m_acc, m_n;
    logic [AW-1:0] m_base;
    wr_t           m_w;

    function automatic logic [DW-1:0] lane_of(input logic [NC*DW-1:0] v, input int k);
        logic signed [DW-1:0] x;
        x = v[k*DW +: DW];
`ifdef WB_RELU_EN
        if (x < 0) x = '0;
`endif
        return x;
    endfunction

    always @(posedge clk or posedge xrst) begin
        if (xrst) begin
            pend.delete();
            m_active = 0;
            m_done   = 0;
            m_total  = 0;
            m_acc    = 0;
            m_base   = '0;
        end else begin
            m_acc_now = m_ready && vec.in_valid;
            if (pend.size() > 0) void'(pend.pop_front());
            if (m_done) begin
                m_active = 0;
                m_done   = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_base   = base_addr;
                    m_total  = int'(total_out);
                    m_acc    = 0;
                    if (m_total == 0) m_done = 1;
                end
            end else begin
                if (m_acc_now) begin
                    m_n = (m_total - m_acc < NC) ? (m_total - m_acc) : NC;
                    for (int k = 0; k < m_n; k++) begin
                        m_w.addr = AW'(int'(m_base) + m_acc + k);
                        m_w.data = lane_of(vec.in_data, k);
                        pend.push_back(m_w);
                    end
                    m_acc += m_n;
                end
                if (m_acc == m_total && pend.size() == 0) m_done = 1;
            end
        end
        m_busy  = m_active;
        m_ready = m_active && !m_done && (m_acc < m_total) && (pend.size() <= 1);
    end

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            rdy;
    } log_t;

    log_t wlog[$];
    int   dlog[$];
    int   busy_cnt = 0;
    log_t le;

    always @(negedge clk) begin
        if (!xrst) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("in_ready", vec.in_ready, m_ready);
            check("we", mem_img_we, pend.size() > 0);
            if (pend.size() > 0 && mem_img_we) begin
                check("addr", mem_img_addr, pend[0].addr);
                check("data", $unsigned(write_mem_img), pend[0].data);
            end
        end
        if (mem_img_we) begin
            le.cyc  = cyc;
            le.addr = mem_img_addr;
            le.data = write_mem_img;
            le.rdy  = vec.in_ready;
            wlog.push_back(le);
        end
        if (done) dlog.push_back(cyc);
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wlog.delete();
        dlog.delete();
        busy_cnt = 0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, " we"},    mem_img_we, 0);
        check({nm, " addr"},  mem_img_addr, 0);
        check({nm, " data"},  $unsigned(write_mem_img), 0);
        check({nm, " ready"}, vec.in_ready, 0);
        check({nm, " busy"},  busy, 0);
        check({nm, " done"},  done, 0);
    endtask

    task automatic do_start(input int b, input int t, output int sc);
        base_addr = AW'(b);
        total_out = LW'(t);
        start     = 1'b1;
        sc        = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_vec(input logic [NC*DW-1:0] v);
        bit r;
        bit ok;
        int b;
        vec.in_valid = 1'b1;
        vec.in_data  = v;
        ok = 0;
        b  = 0;
        while (!ok && b < 60) begin
            @(negedge clk);
            r = vec.in_ready;
            tick();
            b++;
            if (r) ok = 1;
        end
        check("vector accepted", ok, 1);
    endtask

    task automatic wait_done(input string nm);
        int b;
        b = 0;
        while (!done && b < 100) begin
            tick();
            b++;
        end
        check({nm, " done seen"}, b < 100, 1);
        tick();
    endtask

    function automatic logic [NC*DW-1:0] make_vec(input int first);
        logic [NC*DW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*DW +: DW] = DW'(first + k);
        return v;
    endfunction

    int               sc;
    int               exp2 [11] = '{10, 11, 12, 13, 14, 15, 16, 17, 20, 21, 22};
    int               exp5 [4]  = '{'hFFE, 'hFFF, 'h000, 'h001};
    logic [DW-1:0]    exp_neg;
    logic [NC*DW-1:0] v6;
    int               b;

    initial begin
        vec.in_valid = 1'b0;
        vec.in_data  = '0;
        #1;
        check_zero("reset");
        tick();
        tick();
        xrst = 1'b0;
        tick();

        // single full group, in_valid already high
        clear_logs();
        vec.in_valid = 1'b1;
        vec.in_data  = make_vec(1);
        do_start('h100, 8, sc);
        wait_done("t1");
        vec.in_valid = 1'b0;
        check("t1 nwrites", wlog.size(), 8);
        for (int i = 0; i < wlog.size() && i < 8; i++) begin
            check("t1 addr", wlog[i].addr, 'h100 + i);
            check("t1 data", wlog[i].data, i + 1);
        end
        if (wlog.size() == 8 && dlog.size() > 0) begin
            check("t1 first latency", wlog[0].cyc - sc, 2);
            check("t1 contiguous", wlog[7].cyc - wlog[0].cyc, 7);
            check("t1 done after last", dlog[0] - wlog[7].cyc, 1);
        end

        // partial trailing group
        clear_logs();
        do_start(0, 11, sc);
        send_vec(make_vec(10));
        send_vec(make_vec(20));
        vec.in_valid = 1'b0;
        wait_done("t2");
        check("t2 nwrites", wlog.size(), 11);
        for (int i = 0; i < wlog.size() && i < 11; i++) begin
            check("t2 addr", wlog[i].addr, i);
            check("t2 data", wlog[i].data, exp2[i]);
        end
        if (wlog.size() == 11 && dlog.size() > 0)
            check("t2 done after last", dlog[0] - wlog[10].cyc, 1);

        // two groups back to back without a bubble
        clear_logs();
        do_start('h200, 16, sc);
        send_vec(make_vec(40));
        send_vec(make_vec(60));
        vec.in_valid = 1'b0;
        wait_done("t3");
        check("t3 nwrites", wlog.size(), 16);
        if (wlog.size() == 16) begin
            check("t3 contiguous", wlog[15].cyc - wlog[0].cyc, 15);
            check("t3 ready on 8th", wlog[7].rdy, 1);
            check("t3 ready on last", wlog[15].rdy, 0);
            check("t3 data 9th", wlog[8].data, 60);
            check("t3 addr last", wlog[15].addr, 'h20F);
        end

        // empty layer
        clear_logs();
        do_start(5, 0, sc);
        repeat (4) tick();
        check("t4 nwrites", wlog.size(), 0);
        check("t4 ndone", dlog.size(), 1);
        check("t4 busy cycles", busy_cnt, 1);
        if (dlog.size() == 1) check("t4 done cycle", dlog[0] - sc, 1);

        // address wrap
        clear_logs();
        do_start('hFFE, 4, sc);
        send_vec(make_vec(7));
        vec.in_valid = 1'b0;
        wait_done("t5");
        check("t5 nwrites", wlog.size(), 4);
        for (int i = 0; i < wlog.size() && i < 4; i++) begin
            check("t5 addr", wlog[i].addr, exp5[i]);
            check("t5 data", wlog[i].data, 7 + i);
        end

        // negative lane 0 then reset mid-drain
`ifdef WB_RELU_EN
        exp_neg = '0;
`else
        exp_neg = 16'hFFFB;
`endif
        clear_logs();
        v6 = make_vec(100);
        v6[DW-1:0] = 16'hFFFB;
        do_start('h300, 8, sc);
        send_vec(v6);
        vec.in_valid = 1'b0;
        b = 0;
        while (wlog.size() < 3 && b < 20) begin
            tick();
            b++;
        end
        check("t6 drain reached", wlog.size() >= 3, 1);
        if (wlog.size() > 0) check("t6 lane0 data", wlog[0].data, exp_neg);
        xrst = 1'b1;
        #1;
        check_zero("t6 async reset");
        tick();
        xrst = 1'b0;
        clear_logs();
        repeat (5) tick();
        check("t6 idle nwrites", wlog.size(), 0);
        check_zero("t6 idle");
        do_start('h300, 2, sc);
        send_vec(make_vec(50));
        vec.in_valid = 1'b0;
        wait_done("t6 resume");
        check("t6 resume nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("t6 resume addr", wlog[1].addr, 'h301);
            check("t6 resume data", wlog[1].data, 51);
        end

        // randomized layers with random valid gaps and stray start/config changes
        for (int L = 0; L < 40; L++) begin
            vec.in_valid = 1'b0;
            do_start(int'($urandom_range(0, 4095)), int'($urandom_range(0, 40)), sc);
            b = 0;
            while (m_active && b < 500) begin
                vec.in_valid = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < NC; k++) vec.in_data[k*DW +: DW] = DW'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    start     = 1'b1;
                    base_addr = AW'($urandom);
                    total_out = LW'($urandom);
                end else begin
                    start = 1'b0;
                end
                tick();
                b++;
            end
            start = 1'b0;
            check("random layer finishes", b < 500, 1);
        end
        vec.in_valid = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
